// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding, port IDs
// and a small one-hot helper used by the grant logic.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        DARB_IDLE   = 2'd0,
        DARB_ACCESS = 2'd1,
        DARB_RESP   = 2'd2
    } darb_state_t;

    localparam logic DARB_CORE = 1'b0;
    localparam logic DARB_DBG  = 1'b1;

    // Bit 0 is the core, bit 1 is the debug port.
    function automatic logic [1:0] darb_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant with an optional exclusive hold for the
// debug port. Purely combinational; the caller owns last_grant.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    input  logic       i_lock,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_lock && (i_last_grant == DARB_DBG)) begin
            // Held bus: the core is shut out even when debug is idle.
            o_grant = {i_req[1], 1'b0};
        end else if (&i_req) begin
            o_grant = darb_onehot(~i_last_grant);
        end else begin
            o_grant = i_req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core load/store path and a
// debug/DMA master. Define DMEM_ARB_LOCK_EN to add the dbg_lock exclusive hold.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  core_valid,
    output logic                  core_ready,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    input  logic [2:0]            core_width,
    output logic                  core_rsp_valid,
    output logic [DATA_WIDTH-1:0] core_rdata,

    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    input  logic [2:0]            dbg_width,
    output logic                  dbg_rsp_valid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic                  dbg_lock,
`endif

    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [2:0]            mem_data_width,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    darb_state_t           r_state;
    logic                  r_last_grant;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_width;
    logic                  r_mem_we;
    logic                  r_mem_re;
    logic                  r_core_rsp_valid;
    logic                  r_dbg_rsp_valid;

    logic                  w_lock;
    logic [1:0]            w_grant;
    logic [1:0]            w_take;
    logic                  w_accept;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [2:0]            w_sel_width;
    logic                  w_in_access;

`ifdef DMEM_ARB_LOCK_EN
    assign w_lock = dbg_lock;
`else
    assign w_lock = 1'b0;
`endif

    rr_arbiter2 u_rr (
        .i_req        ({dbg_valid, core_valid}),
        .i_last_grant (r_last_grant),
        .i_lock       (w_lock),
        .o_grant      (w_grant)
    );

    // Ready is gated by rst so nothing is handshaken while reset is held.
    assign w_take     = (rst && (r_state == DARB_IDLE)) ? w_grant : 2'b00;
    assign core_ready = w_take[0];
    assign dbg_ready  = w_take[1];
    assign w_accept   = |w_take;

    assign w_sel_we    = w_take[1] ? dbg_we    : core_we;
    assign w_sel_addr  = w_take[1] ? dbg_addr  : core_addr;
    assign w_sel_wdata = w_take[1] ? dbg_wdata : core_wdata;
    assign w_sel_width = w_take[1] ? dbg_width : core_width;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= DARB_IDLE;
            r_last_grant     <= DARB_DBG;
            r_owner          <= DARB_CORE;
            r_we             <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_width          <= 3'd0;
            r_mem_we         <= 1'b0;
            r_mem_re         <= 1'b0;
            r_core_rsp_valid <= 1'b0;
            r_dbg_rsp_valid  <= 1'b0;
        end else begin
            case (r_state)
                DARB_IDLE: begin
                    r_core_rsp_valid <= 1'b0;
                    r_dbg_rsp_valid  <= 1'b0;
                    if (w_accept) begin
                        r_state      <= DARB_ACCESS;
                        r_owner      <= w_take[1];
                        r_last_grant <= w_take[1];
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_width      <= w_sel_width;
                        r_mem_we     <= w_sel_we;
                        r_mem_re     <= ~w_sel_we;
                    end
                end
                DARB_ACCESS: begin
                    r_state          <= DARB_RESP;
                    r_mem_we         <= 1'b0;
                    r_mem_re         <= 1'b0;
                    r_core_rsp_valid <= (r_owner == DARB_CORE);
                    r_dbg_rsp_valid  <= (r_owner == DARB_DBG);
                end
                DARB_RESP: begin
                    r_state          <= DARB_IDLE;
                    r_core_rsp_valid <= 1'b0;
                    r_dbg_rsp_valid  <= 1'b0;
                end
                default: begin
                    r_state          <= DARB_IDLE;
                    r_mem_we         <= 1'b0;
                    r_mem_re         <= 1'b0;
                    r_core_rsp_valid <= 1'b0;
                    r_dbg_rsp_valid  <= 1'b0;
                end
            endcase
        end
    end

    // The memory bus is quiet outside the single strobe cycle.
    assign w_in_access    = r_mem_we | r_mem_re;
    assign mem_we         = r_mem_we;
    assign mem_re         = r_mem_re;
    assign mem_addr       = w_in_access ? r_addr  : '0;
    assign mem_data_in    = w_in_access ? r_wdata : '0;
    assign mem_data_width = w_in_access ? r_width : 3'd0;

    // Read data arrives from memory during the response cycle.
    assign core_rsp_valid = r_core_rsp_valid;
    assign dbg_rsp_valid  = r_dbg_rsp_valid;
    assign core_rdata     = (r_core_rsp_valid && !r_we) ? mem_data_out : '0;
    assign dbg_rdata      = (r_dbg_rsp_valid  && !r_we) ? mem_data_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants and
// responses, a negedge monitor pops and compares them.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          core_valid = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [2:0]    core_width = 3'd2;
    logic          core_ready, core_rsp_valid;
    logic [DW-1:0] core_rdata;
    logic          dbg_valid = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [2:0]    dbg_width = 3'd2;
    logic          dbg_ready, dbg_rsp_valid;
    logic [DW-1:0] dbg_rdata;
`ifdef DMEM_ARB_LOCK_EN
    logic          dbg_lock = 1'b0;
`endif
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [2:0]    mem_data_width;
    logic [DW-1:0] mem_data_out = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .core_valid(core_valid), .core_ready(core_ready), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_width(core_width),
        .core_rsp_valid(core_rsp_valid), .core_rdata(core_rdata),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_width(dbg_width),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rdata(dbg_rdata),
`ifdef DMEM_ARB_LOCK_EN
        .dbg_lock(dbg_lock),
`endif
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_width(mem_data_width),
        .mem_data_out(mem_data_out)
    );

    // Memory model: unwritten words read back as 0xA5000000 | address.
    logic [DW-1:0]     tb_mem [1<<AW];
    logic [(1<<AW)-1:0] tb_wr = '0;
    int cyc = 0;
    int mem_we_cnt = 0;
    int mem_re_cnt = 0;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return tb_wr[a] ? tb_mem[a] : (32'hA500_0000 | {20'h0, a});
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            tb_mem[mem_addr] <= mem_data_in;
            tb_wr[mem_addr]  <= 1'b1;
            mem_we_cnt       <= mem_we_cnt + 1;
        end
        if (mem_re) mem_re_cnt <= mem_re_cnt + 1;
        mem_data_out <= mem_re ? mem_rd(mem_addr) : (32'hBAD0_0000 | DW'(cyc));
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct { logic [DW-1:0] data; int cyc; } rsp_t;
    typedef struct { logic port; int gap; } acc_t;
    rsp_t core_q[$];
    rsp_t dbg_q[$];
    acc_t acc_q[$];

    // Monitor: grants and responses are checked against the queues.
    int   last_acc = 0;
    acc_t m_acc;
    rsp_t m_rsp;
    always @(negedge clk) begin
        if (core_ready || dbg_ready) begin
            chk("ready_onehot", {31'h0, core_ready & dbg_ready}, 32'h0);
            if (acc_q.size() == 0) begin
                chk("unexpected_accept", {31'h0, dbg_ready}, 32'hFFFF_FFFF);
            end else begin
                m_acc = acc_q.pop_front();
                chk("grant_port", {31'h0, dbg_ready}, {31'h0, m_acc.port});
                if (m_acc.gap != 0) chk("accept_gap", DW'(cyc - last_acc), DW'(m_acc.gap));
            end
            $display("accept %s cyc=%0d", dbg_ready ? "dbg" : "core", cyc);
            last_acc = cyc;
        end
        if (core_rsp_valid) begin
            chk("rsp_exclusive", {31'h0, dbg_rsp_valid}, 32'h0);
            if (core_q.size() == 0) begin
                chk("core_spurious_rsp", {31'h0, core_rsp_valid}, 32'h0);
            end else begin
                m_rsp = core_q.pop_front();
                chk("core_rdata", core_rdata, m_rsp.data);
                chk("core_rsp_cyc", DW'(cyc), DW'(m_rsp.cyc));
            end
            $display("rsp core rdata=%h cyc=%0d", core_rdata, cyc);
        end
        if (dbg_rsp_valid) begin
            if (dbg_q.size() == 0) begin
                chk("dbg_spurious_rsp", {31'h0, dbg_rsp_valid}, 32'h0);
            end else begin
                m_rsp = dbg_q.pop_front();
                chk("dbg_rdata", dbg_rdata, m_rsp.data);
                chk("dbg_rsp_cyc", DW'(cyc), DW'(m_rsp.cyc));
            end
            $display("rsp dbg rdata=%h cyc=%0d", dbg_rdata, cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request; returns at the cycle after acceptance (#1 past the edge).
    task automatic drive(input logic port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp, input bit exp_rsp);
        int  n = 0;
        bit  done = 0;
        rsp_t r;
        if (port == 1'b0) begin
            core_valid = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
        end else begin
            dbg_valid = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end
        while (!done) begin
            @(negedge clk);
            if ((port == 1'b0 && core_ready) || (port == 1'b1 && dbg_ready)) begin
                done = 1;
                r.data = exp;
                r.cyc  = cyc + 2;
                if (exp_rsp) begin
                    if (port == 1'b0) core_q.push_back(r);
                    else dbg_q.push_back(r);
                end
            end else begin
                n = n + 1;
                if (n > 40) begin
                    chk(port ? "dbg_accept_timeout" : "core_accept_timeout", 32'h0, 32'h1);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        // Scramble the fields so only the latched copy can reach memory.
        if (port == 1'b0) begin
            core_valid = 1'b0; core_we = ~we; core_addr = '1; core_wdata = 32'h0BAD_F00D;
        end else begin
            dbg_valid = 1'b0; dbg_we = ~we; dbg_addr = '1; dbg_wdata = 32'h0BAD_F00D;
        end
    endtask

    function automatic acc_t mk_acc(input logic p, input int g);
        acc_t a;
        a.port = p;
        a.gap  = g;
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int w0;
    int r0;
    int t;

    initial begin
        core_valid = 1'b1;
        dbg_valid  = 1'b1;
        #2;
        chk("rst_core_ready", {31'h0, core_ready}, 32'h0);
        chk("rst_dbg_ready", {31'h0, dbg_ready}, 32'h0);
        chk("rst_core_rsp_valid", {31'h0, core_rsp_valid}, 32'h0);
        chk("rst_dbg_rsp_valid", {31'h0, dbg_rsp_valid}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_re", {31'h0, mem_re}, 32'h0);
        chk("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        chk("rst_core_rdata", core_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        step(3);
        core_valid = 1'b0;
        dbg_valid  = 1'b0;
        rst = 1'b1;
        step(2);

        // Core load alone.
        acc_q.push_back(mk_acc(1'b0, 0));
        drive(1'b0, 1'b0, 12'h010, 32'h0, 32'hA500_0010, 1'b1);
        chk("load_mem_re", {31'h0, mem_re}, 32'h1);
        chk("load_mem_we", {31'h0, mem_we}, 32'h0);
        chk("load_mem_addr", {20'h0, mem_addr}, 32'h010);
        step(2);

        // Debug store, then core reads it back.
        acc_q.push_back(mk_acc(1'b1, 0));
        w0 = mem_we_cnt;
        drive(1'b1, 1'b1, 12'h020, 32'hDEAD_BEEF, 32'h0, 1'b1);
        chk("store_mem_we", {31'h0, mem_we}, 32'h1);
        chk("store_mem_re", {31'h0, mem_re}, 32'h0);
        chk("store_mem_addr", {20'h0, mem_addr}, 32'h020);
        chk("store_mem_data_in", mem_data_in, 32'hDEAD_BEEF);
        step(2);
        chk("store_we_pulses", DW'(mem_we_cnt - w0), 32'h1);
        acc_q.push_back(mk_acc(1'b0, 0));
        drive(1'b0, 1'b0, 12'h020, 32'h0, 32'hDEAD_BEEF, 1'b1);
        step(2);

        // Core store: zero read data and no read strobe.
        acc_q.push_back(mk_acc(1'b0, 0));
        r0 = mem_re_cnt;
        drive(1'b0, 1'b1, 12'h040, 32'h1234_5678, 32'h0, 1'b1);
        step(2);
        chk("store_no_mem_re", DW'(mem_re_cnt - r0), 32'h0);
        acc_q.push_back(mk_acc(1'b0, 0));
        drive(1'b0, 1'b0, 12'h040, 32'h0, 32'h1234_5678, 1'b1);
        step(2);
        acc_q.push_back(mk_acc(1'b1, 0));
        drive(1'b1, 1'b0, 12'h050, 32'h0, 32'hA500_0050, 1'b1);
        step(2);

        // Continuous contention: strict alternation, accepts 3 cycles apart.
        acc_q.push_back(mk_acc(1'b0, 0));
        for (int i = 0; i < 3; i++) begin
            acc_q.push_back(mk_acc(1'b1, 3));
            acc_q.push_back(mk_acc(1'b0, 3));
        end
        acc_q.push_back(mk_acc(1'b1, 3));
        fork
            for (int i = 0; i < 4; i++)
                drive(1'b0, 1'b0, 12'h100 + 12'(i), 32'h0, 32'hA500_0100 + 32'(i), 1'b1);
            for (int j = 0; j < 4; j++)
                drive(1'b1, 1'b0, 12'h200 + 12'(j), 32'h0, 32'hA500_0200 + 32'(j), 1'b1);
        join
        step(3);

        // Reset during the strobe cycle of a core store: lost, no response.
        acc_q.push_back(mk_acc(1'b0, 0));
        drive(1'b0, 1'b1, 12'h030, 32'h55AA_55AA, 32'h0, 1'b0);
        chk("pre_rst_mem_we", {31'h0, mem_we}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("async_rst_mem_addr", {20'h0, mem_addr}, 32'h0);
        step(2);
        rst = 1'b1;
        step(4);
        chk("rst_store_dropped", mem_rd(12'h030), 32'hA500_0030);

        // First tie after reset goes to the core.
        acc_q.push_back(mk_acc(1'b0, 0));
        acc_q.push_back(mk_acc(1'b1, 3));
        fork
            drive(1'b0, 1'b0, 12'h060, 32'h0, 32'hA500_0060, 1'b1);
            drive(1'b1, 1'b0, 12'h070, 32'h0, 32'hA500_0070, 1'b1);
        join
        step(3);

`ifdef DMEM_ARB_LOCK_EN
        // Locked debug RMW-style burst: core waits until the lock drops.
        dbg_lock = 1'b1;
        acc_q.push_back(mk_acc(1'b1, 0));
        acc_q.push_back(mk_acc(1'b1, 3));
        acc_q.push_back(mk_acc(1'b1, 0));
        acc_q.push_back(mk_acc(1'b0, 3));
        fork
            drive(1'b0, 1'b0, 12'h080, 32'h0, 32'hA500_0080, 1'b1);
            begin
                drive(1'b1, 1'b0, 12'h090, 32'h0, 32'hA500_0090, 1'b1);
                drive(1'b1, 1'b0, 12'h091, 32'h0, 32'hA500_0091, 1'b1);
                step(3);
                drive(1'b1, 1'b1, 12'h091, 32'hCAFE_0001, 32'h0, 1'b1);
                step(1);
                dbg_lock = 1'b0;
            end
        join
        step(3);
`endif

        t = 0;
        while ((core_q.size() != 0 || dbg_q.size() != 0 || acc_q.size() != 0) && t < 20) begin
            step(1);
            t++;
        end
        chk("core_q_drained", DW'(core_q.size()), 32'h0);
        chk("dbg_q_drained", DW'(dbg_q.size()), 32'h0);
        chk("acc_q_drained", DW'(acc_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported `data_memory` between the core's load/store path and a debug/DMA port. The core's `data_path` load/store signals and the debug master each talk to it with a valid/ready request channel and a response pulse. The arbiter sequences every access through a fixed three-state FSM and drives `data_memory`'s `we`/`re`/`addr`/`data_in`/`data_width` pins. Ties between the two ports are broken round-robin.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width; matches `` `DATA_WIDTH ``.
- `ADDR_WIDTH`, 12, memory address width; matches `` `DATA_MEM_WIDTH ``.

Ports:
- Clock and reset (already decided): one clock, `clk`; reset `rst` is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `core_valid`  in  1  core request valid.
- `core_ready`  out  1  core request accepted this cycle.
- `core_we`  in  1  1 = store, 0 = load.
- `core_addr`  in  ADDR_WIDTH  byte address.
- `core_wdata`  in  DATA_WIDTH  store data.
- `core_width`  in  3  funct3-style width code, passed through unchanged.
- `core_rsp_valid`  out  1  one-cycle response pulse.
- `core_rdata`  out  DATA_WIDTH  load data, valid with `core_rsp_valid`.
- `dbg_valid`, `dbg_ready`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_width`, `dbg_rsp_valid`, `dbg_rdata`: same directions and widths as the core group, for the debug port.
- `dbg_lock`  in  1  exclusive-hold request; present only with `DMEM_ARB_LOCK_EN`.
- `mem_we`, `mem_re`  out  1  to `data_memory`.
- `mem_addr`  out  ADDR_WIDTH  to `data_memory`.
- `mem_data_in`  out  DATA_WIDTH  to `data_memory`.
- `mem_data_width`  out  3  to `data_memory`.
- `mem_data_out`  in  DATA_WIDTH  from `data_memory`; valid in the cycle after `mem_re`.

## Operation
- FSM states: `IDLE`, `ACCESS`, `RESP`. Transitions: `IDLE`→`ACCESS` when a request is accepted; `ACCESS`→`RESP` unconditionally; `RESP`→`IDLE` unconditionally.
- In `IDLE`:
  - If any valid is high, grant exactly one port.
  - Assert that port's `*_ready` combinationally in the same cycle.
  - Latch `we`, `addr`, `wdata`, `width` and the owner ID.
- Arbitration:
  - Only one port valid: that port wins.
  - Both valid: the port not granted last wins.
  - `last_grant` resets to dbg, so the core wins the first tie.
- In `ACCESS`:
  - `mem_re = !we_q`, `mem_we = we_q`.
  - `mem_addr`, `mem_data_in` and `mem_data_width` come from the latched request.
  - Exactly one memory strobe is high, for exactly one cycle.
- In `RESP`:
  - Pulse the owner's `*_rsp_valid`.
  - `*_rdata = mem_data_out` for loads, 0 for stores.
  - The other port's `rsp_valid` stays 0.
- Outside `ACCESS`, all `mem_*` outputs are 0.
- Requester rule: hold `valid` and the request fields stable until `ready`. The arbiter samples them only in the accepting cycle.
- Address and width are not checked; misalignment handling belongs to `data_memory`.

## Timing
- Reset values: state = `IDLE`, `last_grant` = dbg. All `*_ready`, `*_rsp_valid`, `mem_we` and `mem_re` are 0. `*_rdata`, `mem_addr` and `mem_data_in` are 0.
- Latency: accept at cycle T, memory strobe at T+1, response at T+2. The next acceptance is possible at T+3, giving a peak rate of one access per 3 cycles.
- No acceptance in `ACCESS` or `RESP`; `ready` is low for both ports in those states.
- Simultaneous valid in `IDLE`: grant follows the round-robin rule. Under continuous contention the ports alternate strictly.
- Reset mid-operation: state returns to `IDLE` immediately and asynchronously, and `mem_we`/`mem_re` drop in the same instant. An in-flight transaction is lost with no response.
- A valid that arrives in `RESP` is accepted in the next `IDLE` cycle.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - The `dbg_lock` port exists.
  - While dbg owns the last grant and `dbg_lock` = 1, `IDLE` grants only dbg. `core_ready` is held 0 even if dbg is not valid.
  - The lock releases in the first `IDLE` cycle with `dbg_lock` = 0. This supports atomic read-modify-write from the debug master.
- Undefined: no `dbg_lock` port; pure round-robin.

## Structure
- Shared definitions go in `include/common.vh`: FSM state encodings (`` `DARB_IDLE ``, `` `DARB_ACCESS ``, `` `DARB_RESP ``) and port IDs (`` `DARB_CORE ``, `` `DARB_DBG ``).
- Sub-module `rr_arbiter2`: takes two requests, `last_grant` and an optional lock, and outputs a combinational one-hot grant.
- The FSM, request latches and memory drive stay in `dmem_arbiter`.

## Test plan
- Core load alone: `core_valid`=1, `we`=0, `addr`=0x010.
  - `core_ready` in cycle 0.
  - `mem_re`=1 with `mem_addr`=0x010 in cycle 1.
  - `core_rsp_valid`=1 with `core_rdata` = memory word in cycle 2.
- Dbg store 0xDEADBEEF to 0x020, then core load from 0x020.
  - Exactly one `mem_we` pulse for the store.
  - Core load returns 0xDEADBEEF.
  - `dbg_rdata`=0 on the store response.
- Both ports valid continuously for 4 transactions each.
  - Grant order core, dbg, core, dbg, …
  - Accepts exactly 3 cycles apart; one response per transaction, to the correct port.
- `rst` low during `ACCESS` of a store.
  - `mem_we` goes to 0 the same cycle; no `rsp_valid` follows.
  - After release, the first tie goes to the core.
- `DMEM_ARB_LOCK_EN` defined: `dbg_lock`=1 with 3 dbg requests while `core_valid`=1.
  - All 3 dbg requests are served before the core.
  - Core is accepted in the first `IDLE` after `dbg_lock`=0.
- Write response check: `core_we`=1.
  - `core_rsp_valid` pulses at T+2 with `core_rdata`=0.
  - `mem_re` is never asserted.
